// File: rtl/mul_mdc_job_sequencer_pkg.sv
// Shared types and sizing for the mul_mdc job sequencer and its engine-side bundle.
// Engine control/flag structs mirror the engine's ctrl/flags ports field for field.
package mul_mdc_job_sequencer_pkg;

    localparam int unsigned MUL_MDC_CNT_LEN       = 1024;
    localparam int unsigned MUL_MDC_LEN_W         = 32;
    localparam int unsigned MUL_MDC_SEQ_TIMEOUT_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STRM    = 3'd1,
        ENG     = 3'd2,
        COMPUTE = 3'd3,
        DRAIN   = 3'd4,
        FINISH  = 3'd5
    } seq_state_t;

    typedef struct packed {
        logic                     clear;
        logic                     start;
        logic [MUL_MDC_LEN_W-1:0] len;
        logic [MUL_MDC_LEN_W-1:0] shift;
        logic [MUL_MDC_LEN_W-1:0] simple_mul;
    } ctrl_engine_t;

    typedef struct packed {
        logic ready;
        logic done;
    } flags_engine_t;

endpackage

// File: rtl/mul_mdc_job_sequencer_if.sv
// Engine/streamer-side bundle of the job sequencer: streamer start handshakes,
// engine ctrl/flags and a snoop of the engine d output handshake.
interface mul_mdc_job_sequencer_if;
    import mul_mdc_job_sequencer_pkg::*;

    logic [3:0]    strm_req;
    logic [3:0]    strm_ack;
    logic          strm_d_done;
    ctrl_engine_t  ctrl;
    flags_engine_t flags;
    logic          d_valid;
    logic          d_ready;

    modport master (
        output strm_req,
        output ctrl,
        input  strm_ack,
        input  strm_d_done,
        input  flags,
        input  d_valid,
        input  d_ready
    );

    modport slave (
        input  strm_req,
        input  ctrl,
        output strm_ack,
        output strm_d_done,
        output flags,
        output d_valid,
        output d_ready
    );

endinterface

// File: rtl/mul_mdc_job_sequencer.sv
// Purpose: job-level controller launching streamers and engine, counting d outputs, signalling done.
// Latency: job_start -> strm_req next cycle; done/evt 2 cycles after last d handshake with drain seen.
// Backpressure: waits on streamer acks, engine ready and sink drain; d handshakes are only snooped.
module mul_mdc_job_sequencer
    import mul_mdc_job_sequencer_pkg::*;
#(
    parameter int unsigned CNT_LEN   = MUL_MDC_CNT_LEN,
    parameter int unsigned LEN_W     = MUL_MDC_LEN_W,
    parameter int unsigned TIMEOUT_W = MUL_MDC_SEQ_TIMEOUT_W
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       test_mode_i,
    input  logic                       clear_i,
    input  logic                       job_start_i,
    input  logic [LEN_W-1:0]           reg_len_i,
    input  logic [LEN_W-1:0]           reg_shift_i,
    input  logic [LEN_W-1:0]           reg_simple_mul_i,
    mul_mdc_job_sequencer_if.master    eng,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       evt_o,
    output logic                       err_o,
    output logic [$clog2(CNT_LEN):0]   cnt_o
);

    localparam int unsigned CNT_W = $clog2(CNT_LEN) + 1;

    seq_state_t           state_q;
    logic [3:0]           acked_q;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     shift_q;
    logic [LEN_W-1:0]     smul_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [TIMEOUT_W-1:0] wdog_q;
    logic                 err_q;
    logic                 start_q;
    logic                 fin_q;
    logic                 clr_q;

    logic                 hs;
    logic [CNT_W-1:0]     cnt_inc;
    logic [3:0]           acked_nxt;
    logic                 len_zero;
    logic                 len_over;
    logic                 unused_test_mode;

    assign unused_test_mode = test_mode_i;

    assign hs        = eng.d_valid & eng.d_ready;
    assign cnt_inc   = (hs && (cnt_q != CNT_W'(CNT_LEN))) ? cnt_q + 1'b1 : cnt_q;
    assign acked_nxt = acked_q | eng.strm_ack;
    assign len_zero  = (reg_len_i == '0);
    assign len_over  = (reg_len_i > LEN_W'(CNT_LEN));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            acked_q <= '0;
            len_q   <= '0;
            shift_q <= '0;
            smul_q  <= '0;
            cnt_q   <= '0;
            wdog_q  <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            fin_q   <= 1'b0;
            clr_q   <= 1'b0;
        end else if (clear_i) begin
            state_q <= IDLE;
            acked_q <= '0;
            cnt_q   <= '0;
            wdog_q  <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            fin_q   <= 1'b0;
            clr_q   <= 1'b1;
        end else begin
            start_q <= 1'b0;
            fin_q   <= 1'b0;
            clr_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (job_start_i) begin
                        len_q   <= reg_len_i;
                        shift_q <= reg_shift_i;
                        smul_q  <= reg_simple_mul_i;
                        cnt_q   <= '0;
                        acked_q <= '0;
                        err_q   <= len_over;
                        // Empty or oversized jobs complete at once without touching the engine.
                        if (len_zero || len_over) begin
                            state_q <= FINISH;
                            fin_q   <= 1'b1;
                        end else begin
                            state_q <= STRM;
                        end
                    end
                end
                STRM: begin
                    acked_q <= acked_nxt;
                    if (&acked_nxt) begin
                        state_q <= ENG;
                    end
                end
                ENG: begin
                    if (eng.flags.ready) begin
                        start_q <= 1'b1;
                        wdog_q  <= '0;
                        state_q <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    cnt_q  <= cnt_inc;
                    wdog_q <= hs ? '0 : wdog_q + 1'b1;
                    // The count includes a handshake landing in the same cycle as eng done.
                    if (eng.flags.done) begin
                        if (LEN_W'(cnt_inc) != len_q) begin
                            err_q <= 1'b1;
                        end
                        state_q <= DRAIN;
                    end else if (!hs && (&wdog_q)) begin
                        err_q   <= 1'b1;
                        state_q <= FINISH;
                        fin_q   <= 1'b1;
                        clr_q   <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (eng.strm_d_done) begin
                        state_q <= FINISH;
                        fin_q   <= 1'b1;
                        clr_q   <= 1'b1;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign eng.strm_req = (state_q == STRM) ? ~acked_q : 4'b0000;
    assign eng.ctrl     = '{clear:      clr_q,
                            start:      start_q,
                            len:        MUL_MDC_LEN_W'(len_q),
                            shift:      MUL_MDC_LEN_W'(shift_q),
                            simple_mul: MUL_MDC_LEN_W'(smul_q)};

    assign busy_o = (state_q != IDLE);
    assign done_o = fin_q;
    assign evt_o  = fin_q;
    assign err_o  = err_q;
    assign cnt_o  = cnt_q;

endmodule

// File: tb/tb_mul_mdc_job_sequencer.sv
// Directed bench for mul_mdc_job_sequencer: nominal, staggered acks, mismatch,
// length boundaries, soft clear and watchdog scenarios.
module tb_mul_mdc_job_sequencer;
    import mul_mdc_job_sequencer_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        test_mode_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        job_start_i = 1'b0;
    logic [31:0] reg_len_i = '0;
    logic [31:0] reg_shift_i = '0;
    logic [31:0] reg_simple_mul_i = '0;
    logic        busy_o;
    logic        done_o;
    logic        evt_o;
    logic        err_o;
    logic [10:0] cnt_o;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_seen = 0;
    int start_seen = 0;
    int req_seen = 0;

    mul_mdc_job_sequencer_if eng_if ();

    mul_mdc_job_sequencer #(
        .CNT_LEN   (1024),
        .LEN_W     (32),
        .TIMEOUT_W (8)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .test_mode_i      (test_mode_i),
        .clear_i          (clear_i),
        .job_start_i      (job_start_i),
        .reg_len_i        (reg_len_i),
        .reg_shift_i      (reg_shift_i),
        .reg_simple_mul_i (reg_simple_mul_i),
        .eng              (eng_if.master),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .evt_o            (evt_o),
        .err_o            (err_o),
        .cnt_o            (cnt_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (done_o === 1'b1) done_seen++;
        if (eng_if.ctrl.start === 1'b1) start_seen++;
        if (eng_if.strm_req !== 4'b0000) req_seen++;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic set_hs(input logic v);
        eng_if.d_valid = v;
        eng_if.d_ready = v;
    endtask

    task automatic launch(input logic [31:0] len);
        reg_len_i = len;
        job_start_i = 1'b1;
        step();
        job_start_i = 1'b0;
        eng_if.strm_ack = 4'b1111;
        step();
        eng_if.strm_ack = 4'b0000;
        step();
    endtask

    task automatic wait_done(input int budget, output int n);
        n = -1;
        for (int i = 0; i < budget; i++) begin
            if (done_o === 1'b1) begin
                n = i;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        step(); step(); step();
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
        total++; if ({done_o, evt_o, err_o} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {done_o, evt_o, err_o}); end
        total++; if (cnt_o !== 11'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", cnt_o); end
        total++; if (eng_if.strm_req !== 4'b0000) begin bad++; $display("FAIL rst_req got=%b exp=0000", eng_if.strm_req); end
        total++; if ({eng_if.ctrl.start, eng_if.ctrl.clear} !== 2'b00) begin bad++; $display("FAIL rst_ctrl got=%b exp=00", {eng_if.ctrl.start, eng_if.ctrl.clear}); end
        total++; if (eng_if.ctrl.len !== 32'd0) begin bad++; $display("FAIL rst_len got=%0d exp=0", eng_if.ctrl.len); end
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_nominal();
        int b_done, b_start;
        b_done = done_seen; b_start = start_seen;
        reg_len_i = 8; reg_shift_i = 3; reg_simple_mul_i = 1;
        eng_if.flags.ready = 1'b1;
        eng_if.strm_d_done = 1'b1;
        job_start_i = 1'b1;
        step();
        job_start_i = 1'b0;
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL nom_busy got=%b exp=1", busy_o); end
        total++; if (eng_if.strm_req !== 4'b1111) begin bad++; $display("FAIL nom_req got=%b exp=1111", eng_if.strm_req); end
        step();
        eng_if.strm_ack = 4'b1111;
        step();
        eng_if.strm_ack = 4'b0000;
        total++; if (eng_if.strm_req !== 4'b0000) begin bad++; $display("FAIL nom_req_drop got=%b exp=0000", eng_if.strm_req); end
        total++; if (eng_if.ctrl.start !== 1'b0) begin bad++; $display("FAIL nom_start_early got=%b exp=0", eng_if.ctrl.start); end
        total++; if ({eng_if.ctrl.len, eng_if.ctrl.shift} !== {32'd8, 32'd3}) begin bad++; $display("FAIL nom_params got=%0d/%0d exp=8/3", eng_if.ctrl.len, eng_if.ctrl.shift); end
        step();
        total++; if (eng_if.ctrl.start !== 1'b1) begin bad++; $display("FAIL nom_start got=%b exp=1", eng_if.ctrl.start); end
        for (int i = 0; i < 8; i++) begin
            set_hs(1'b1);
            eng_if.flags.done = (i == 7);
            step();
        end
        set_hs(1'b0);
        eng_if.flags.done = 1'b0;
        total++; if (cnt_o !== 11'd8) begin bad++; $display("FAIL nom_cnt got=%0d exp=8", cnt_o); end
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL nom_done_early got=%b exp=0", done_o); end
        step();
        total++; if ({done_o, evt_o, eng_if.ctrl.clear, err_o} !== 4'b1110) begin bad++; $display("FAIL nom_finish got=%b exp=1110", {done_o, evt_o, eng_if.ctrl.clear, err_o}); end
        step();
        total++; if (busy_o !== 1'b0 || cnt_o !== 11'd8) begin bad++; $display("FAIL nom_idle got=busy%b cnt%0d exp=busy0 cnt8", busy_o, cnt_o); end
        total++; if (done_seen - b_done !== 1 || start_seen - b_start !== 1) begin bad++; $display("FAIL nom_pulses got=done%0d start%0d exp=1/1", done_seen - b_done, start_seen - b_start); end
    endtask

    task automatic test_staggered();
        int b_start, n;
        b_start = start_seen;
        reg_len_i = 2;
        eng_if.flags.ready = 1'b0;
        job_start_i = 1'b1;
        step();
        job_start_i = 1'b0;
        step();
        eng_if.strm_ack = 4'b0001;
        step();
        eng_if.strm_ack = 4'b0000;
        total++; if (eng_if.strm_req !== 4'b1110) begin bad++; $display("FAIL stg_req_a got=%b exp=1110", eng_if.strm_req); end
        step();
        eng_if.strm_ack = 4'b1100;
        step();
        eng_if.strm_ack = 4'b0000;
        total++; if (eng_if.strm_req !== 4'b0010) begin bad++; $display("FAIL stg_req_cd got=%b exp=0010", eng_if.strm_req); end
        step(); step();
        total++; if (eng_if.strm_req !== 4'b0010) begin bad++; $display("FAIL stg_req_hold got=%b exp=0010", eng_if.strm_req); end
        step();
        eng_if.strm_ack = 4'b0010;
        step();
        eng_if.strm_ack = 4'b0000;
        total++; if (eng_if.strm_req !== 4'b0000 || busy_o !== 1'b1) begin bad++; $display("FAIL stg_req_b got=%b exp=0000", eng_if.strm_req); end
        step();
        total++; if (start_seen != b_start) begin bad++; $display("FAIL stg_no_ready_start got=%0d exp=0", start_seen - b_start); end
        eng_if.flags.ready = 1'b1;
        step();
        total++; if (eng_if.ctrl.start !== 1'b1) begin bad++; $display("FAIL stg_start got=%b exp=1", eng_if.ctrl.start); end
        for (int i = 0; i < 2; i++) begin
            set_hs(1'b1);
            eng_if.flags.done = (i == 1);
            step();
        end
        set_hs(1'b0);
        eng_if.flags.done = 1'b0;
        wait_done(10, n);
        total++; if (n < 0 || cnt_o !== 11'd2 || err_o !== 1'b0) begin bad++; $display("FAIL stg_done got=wait%0d cnt%0d err%b exp=cnt2 err0", n, cnt_o, err_o); end
        step();
    endtask

    task automatic test_mismatch();
        int b_done;
        b_done = done_seen;
        eng_if.strm_d_done = 1'b0;
        launch(8);
        for (int i = 0; i < 6; i++) begin
            set_hs(1'b1);
            eng_if.flags.done = (i == 5);
            step();
        end
        set_hs(1'b0);
        eng_if.flags.done = 1'b0;
        total++; if (err_o !== 1'b1 || cnt_o !== 11'd6) begin bad++; $display("FAIL mis_err got=err%b cnt%0d exp=err1 cnt6", err_o, cnt_o); end
        step(); step(); step();
        total++; if (done_seen != b_done || busy_o !== 1'b1) begin bad++; $display("FAIL mis_wait_drain got=done%0d busy%b exp=0/1", done_seen - b_done, busy_o); end
        eng_if.strm_d_done = 1'b1;
        step();
        total++; if (done_o !== 1'b1 || err_o !== 1'b1) begin bad++; $display("FAIL mis_done got=done%b err%b exp=1/1", done_o, err_o); end
        step();
        total++; if (err_o !== 1'b1 || busy_o !== 1'b0) begin bad++; $display("FAIL mis_sticky got=err%b busy%b exp=1/0", err_o, busy_o); end
    endtask

    task automatic test_boundary();
        int b_req, b_start;
        b_req = req_seen; b_start = start_seen;
        reg_len_i = 0;
        job_start_i = 1'b1;
        step();
        job_start_i = 1'b0;
        total++; if ({done_o, evt_o, err_o} !== 3'b110) begin bad++; $display("FAIL len0_done got=%b exp=110", {done_o, evt_o, err_o}); end
        step();
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL len0_idle got=%b exp=0", busy_o); end
        reg_len_i = 1025;
        job_start_i = 1'b1;
        step();
        job_start_i = 1'b0;
        total++; if ({done_o, err_o} !== 2'b11) begin bad++; $display("FAIL lenover_done got=%b exp=11", {done_o, err_o}); end
        step();
        total++; if (req_seen != b_req || start_seen != b_start || busy_o !== 1'b0) begin bad++; $display("FAIL boundary_quiet got=req%0d start%0d exp=0/0", req_seen - b_req, start_seen - b_start); end
    endtask

    task automatic test_clear();
        int b_done, n;
        launch(8);
        for (int i = 0; i < 3; i++) begin
            set_hs(1'b1);
            step();
        end
        set_hs(1'b0);
        b_done = done_seen;
        total++; if (cnt_o !== 11'd3) begin bad++; $display("FAIL clr_pre_cnt got=%0d exp=3", cnt_o); end
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        total++; if ({busy_o, eng_if.ctrl.clear, err_o} !== 3'b010 || cnt_o !== 11'd0) begin bad++; $display("FAIL clr_effect got=%b cnt%0d exp=010 cnt0", {busy_o, eng_if.ctrl.clear, err_o}, cnt_o); end
        step(); step();
        total++; if (done_seen != b_done) begin bad++; $display("FAIL clr_no_done got=%0d exp=0", done_seen - b_done); end
        launch(4);
        for (int i = 0; i < 4; i++) begin
            set_hs(1'b1);
            eng_if.flags.done = (i == 3);
            step();
        end
        set_hs(1'b0);
        eng_if.flags.done = 1'b0;
        wait_done(10, n);
        total++; if (n < 0 || cnt_o !== 11'd4 || err_o !== 1'b0) begin bad++; $display("FAIL clr_next_job got=wait%0d cnt%0d err%b exp=cnt4 err0", n, cnt_o, err_o); end
        step();
    endtask

    task automatic test_watchdog();
        int b_done, b_start, s, n;
        b_done = done_seen; b_start = start_seen;
        launch(5);
        s = cyc;
        for (int i = 0; i < 10; i++) step();
        reg_len_i = 0;
        job_start_i = 1'b1;
        step();
        job_start_i = 1'b0;
        total++; if (busy_o !== 1'b1 || done_o !== 1'b0 || eng_if.ctrl.len !== 32'd5) begin bad++; $display("FAIL wd_ignore_start got=busy%b done%b len%0d exp=1/0/5", busy_o, done_o, eng_if.ctrl.len); end
        wait_done(400, n);
        total++; if (cyc - s !== 256) begin bad++; $display("FAIL wd_latency got=%0d exp=256 (wait=%0d)", cyc - s, n); end
        total++; if (err_o !== 1'b1 || cnt_o !== 11'd0) begin bad++; $display("FAIL wd_err got=err%b cnt%0d exp=1/0", err_o, cnt_o); end
        step(); step(); step();
        total++; if (busy_o !== 1'b0 || done_seen - b_done !== 1 || start_seen - b_start !== 1) begin bad++; $display("FAIL wd_no_restart got=busy%b done%0d start%0d exp=0/1/1", busy_o, done_seen - b_done, start_seen - b_start); end
    endtask

    initial begin
        eng_if.strm_ack = 4'b0000;
        eng_if.strm_d_done = 1'b0;
        eng_if.flags.ready = 1'b0;
        eng_if.flags.done = 1'b0;
        eng_if.d_valid = 1'b0;
        eng_if.d_ready = 1'b0;
        test_reset();
        test_nominal();
        test_staggered();
        test_mismatch();
        test_boundary();
        test_clear();
        test_watchdog();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout got=time%0t exp=finish before", $time);
        $fatal(1);
    end

endmodule
